gand16: RTL and testbench

GAND16 -- requirements
Module: gand16

---
 rtl/gand16_pkg.sv | 15 +
 rtl/gand16_popcnt.sv | 30 +++
 rtl/gand16.sv | 93 +++++++++
 tb/tb_gand16.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gand16_pkg.sv
// gand16_pkg: shared constants for the gand16 registered bitwise-AND block.
//   WIDTH_DEF : default operand/result width
//   CNT_W     : width of the set-bit count (holds 0..16)
//   Y_RST, ZERO_RST, ONES_RST : values driven while rst_n is low
package gand16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W     = 5;

    localparam logic [WIDTH_DEF-1:0] Y_RST    = '0;
    // y resets to zero, so the zero flag resets high to stay consistent with y.
    localparam logic                 ZERO_RST = 1'b1;
    localparam logic                 ONES_RST = 1'b0;

endpackage

// File: rtl/gand16_popcnt.sv
// gand16_popcnt: combinational count of set bits.
// Ports:
//   bits  [WIDTH-1:0] in  : vector to count
//   count [CNT_W-1:0] out : number of ones in bits
module gand16_popcnt
    import gand16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] bits,
    output logic [CNT_W-1:0] count
);

    // Each bit zero-extended to the count width so the sum needs no casts.
    logic [CNT_W-1:0] bit_ext [WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
            assign bit_ext[gi] = CNT_W'(bits[gi]);
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + bit_ext[i];
        end
    end

endmodule

// File: rtl/gand16.sv
// gand16: registered bitwise AND with zero/all-ones flags and optional popcount.
// Result and flags are loaded together from a & b on every edge where
// in_valid is high and hold otherwise; out_valid is in_valid delayed one edge.
// Ports:
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   a, b       in  : operands [WIDTH-1:0]
//   in_valid   in  : a/b qualify this cycle
//   y          out : registered a & b
//   out_valid  out : y was loaded on the previous edge
//   zero       out : y == 0
//   ones       out : y == all ones
//   popcnt     out : number of set bits in y [CNT_W-1:0]
// Build option: define GAND16_POPCNT_EN to compute popcnt; otherwise popcnt
// is tied to 0 and no counting logic exists.
module gand16
    import gand16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             zero,
    output logic             ones,
    output logic [CNT_W-1:0] popcnt
);

    logic [WIDTH-1:0] y_next;
    logic             zero_next;
    logic             ones_next;

    logic [WIDTH-1:0] y_reg;
    logic             out_valid_reg;
    logic             zero_reg;
    logic             ones_reg;

    // Flags derive from the same value that loads y, so they can never
    // disagree with the registered result.
    assign y_next    = a & b;
    assign zero_next = (y_next == '0);
    assign ones_next = &y_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg         <= WIDTH'(Y_RST);
            out_valid_reg <= 1'b0;
            zero_reg      <= ZERO_RST;
            ones_reg      <= ONES_RST;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                y_reg    <= y_next;
                zero_reg <= zero_next;
                ones_reg <= ones_next;
            end
        end
    end

    assign y         = y_reg;
    assign out_valid = out_valid_reg;
    assign zero      = zero_reg;
    assign ones      = ones_reg;

`ifdef GAND16_POPCNT_EN
    logic [CNT_W-1:0] popcnt_next;
    logic [CNT_W-1:0] popcnt_reg;

    gand16_popcnt #(
        .WIDTH (WIDTH)
    ) u_popcnt (
        .bits  (y_next),
        .count (popcnt_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            popcnt_reg <= '0;
        end else if (in_valid) begin
            popcnt_reg <= popcnt_next;
        end
    end

    assign popcnt = popcnt_reg;
`else
    assign popcnt = '0;
`endif

endmodule

// File: tb/tb_gand16.sv
// tb_gand16: directed self-checking bench for gand16 (WIDTH=16).
// Expected results are queued when a valid input is driven and popped when
// the corresponding output is due. Popcount expectations follow the same
// GAND16_POPCNT_EN define as the design build.
module tb_gand16;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        in_valid;
    logic [15:0] y;
    logic        out_valid;
    logic        zero;
    logic        ones;
    logic [4:0]  popcnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] sb_q [$];
    logic [15:0] model_y;

    gand16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .y         (y),
        .out_valid (out_valid),
        .zero      (zero),
        .ones      (ones),
        .popcnt    (popcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_popcnt(input logic [15:0] v);
`ifdef GAND16_POPCNT_EN
        return 16'($countones(v));
`else
        return 16'(v & 16'h0);
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_valid);
        check({tag, ".out_valid"}, 16'(out_valid), 16'(exp_valid));
        check({tag, ".y"},         y,              model_y);
        check({tag, ".zero"},      16'(zero),      16'(model_y == 16'h0));
        check({tag, ".ones"},      16'(ones),      16'(model_y == 16'hFFFF));
        check({tag, ".popcnt"},    16'(popcnt),    exp_popcnt(model_y));
    endtask

    // One clock of stimulus; outputs sampled 1 time unit after the edge.
    task automatic step(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input logic tv);
        @(negedge clk);
        a = ta;
        b = tb_v;
        in_valid = tv;
        if (tv) sb_q.push_back(ta & tb_v);
        @(posedge clk);
        #1;
        if (tv) begin
            if (sb_q.size() == 0) begin
                check({tag, ".sb_empty"}, 16'd1, 16'd0);
            end else begin
                model_y = sb_q.pop_front();
            end
        end
        check_outputs(tag, tv);
    endtask

    // Assert reset part-way through a cycle and check outputs clear at once.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        model_y = 16'h0;
        check_outputs(tag, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        a        = '0;
        b        = '0;
        in_valid = 1'b0;
        model_y  = 16'h0;

        // Reset state with inputs toggling; clocks run while reset is held.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        check_outputs("reset_hold", 1'b0);
        in_valid = 1'b0;
        release_reset();

        // Single-bit truth table.
        step("tt00", 16'h0000, 16'h0000, 1'b1);
        step("tt01", 16'h0000, 16'h0001, 1'b1);
        step("tt10", 16'h0001, 16'h0000, 1'b1);
        step("tt11", 16'h0001, 16'h0001, 1'b1);

        // Full-width patterns.
        step("full_ones", 16'hFFFF, 16'hFFFF, 1'b1);
        step("full_a5",   16'hA5A5, 16'h0FF0, 1'b1);

        // Hold behaviour while in_valid is low.
        step("hold_load", 16'h00FF, 16'hFFFF, 1'b1);
        step("hold_1",    16'hFFFF, 16'hFFFF, 1'b0);
        step("hold_2",    16'hFFFF, 16'hFFFF, 1'b0);

        // Four back-to-back valid inputs.
        step("stream0", 16'h1234, 16'hFF00, 1'b1);
        step("stream1", 16'hDEAD, 16'hBEEF, 1'b1);
        step("stream2", 16'hFFFF, 16'h8001, 1'b1);
        step("stream3", 16'h7FFE, 16'hFFFF, 1'b1);
        step("stream_end", 16'h0000, 16'h0000, 1'b0);

        // Reset after the second of a stream discards the in-flight result.
        step("mid0", 16'h1234, 16'hFFFF, 1'b1);
        step("mid1", 16'h5678, 16'h0F0F, 1'b1);
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
        async_reset("mid_rst");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_outputs("mid_rst_held", 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_reset();
        step("after_rst_idle0", 16'hFFFF, 16'hFFFF, 1'b0);
        step("after_rst_idle1", 16'hFFFF, 16'hFFFF, 1'b0);

        // Valid input on the very first edge after reset release.
        async_reset("rst2");
        release_reset();
        step("first_edge", 16'hF0F0, 16'hFFFF, 1'b1);
        step("first_edge_next", 16'hC3C3, 16'h3C3C, 1'b1);

        // Random mix of valid and idle cycles.
        for (int i = 0; i < 20; i++) begin
            step("rand", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
